// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
// Default geometry: 64 one-word lines, 24-bit tags.
package icache_pkg;

    localparam int ICACHE_IDX_W = 6;

    typedef enum logic [1:0] {
        ICACHE_IDLE      = 2'd0,
        ICACHE_MISS      = 2'd1,
        ICACHE_WAIT_DROP = 2'd2
    } icache_state_e;

    function automatic logic [31:0] line_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and MemCtrl-side handshake bundles for the icache.
// fetch: fetcher is master; mem: icache is master toward MemCtrl.
interface icache_fetch_if;
    logic        req;
    logic [31:0] pc;
    logic        ready;
    logic        valid;
    logic [31:0] inst;

    modport master (output req, pc, input ready, valid, inst);
    modport slave  (input req, pc, output ready, valid, inst);
endinterface

interface icache_mem_if;
    logic [31:0] addr;
    logic        req;
    logic [31:0] data;
    logic        done;

    modport master (output addr, req, input data, done);
    modport slave  (input addr, req, output data, done);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one write port.
// Valid bits clear asynchronously; tag/data are never reset.
module icache_line_array #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);
    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line icache in front of MemCtrl's I-port.
// Define ICACHE_PERF_EN to build the hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    icache_fetch_if.slave       fetch,
    icache_mem_if.master        mem,
    output logic [31:0]         perf_hit,
    output logic [31:0]         perf_miss
);
    icache_state_e state_q, state_d;
    logic          valid_q, valid_d;
    logic [31:0]   inst_q, inst_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          we, hit_inc, miss_inc;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit, accept;

    icache_line_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch.pc[IDX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (we),
        .wr_idx   (addr_q[IDX_W+1:2]),
        .wr_tag   (addr_q[31:IDX_W+2]),
        .wr_data  (mem.data)
    );

    assign accept = fetch.req && rdy && !flush;
    assign hit    = rd_valid && (rd_tag == fetch.pc[31:IDX_W+2]);

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        inst_d   = inst_q;
        req_d    = req_q;
        addr_d   = addr_q;
        we       = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        if (!rdy) begin
            valid_d = valid_q;
        end else begin
            unique case (state_q)
                ICACHE_IDLE: begin
                    if (accept && hit) begin
                        valid_d = 1'b1;
                        inst_d  = rd_data;
                        hit_inc = 1'b1;
                    end else if (accept) begin
                        req_d    = 1'b1;
                        addr_d   = line_addr(fetch.pc);
                        state_d  = ICACHE_MISS;
                        miss_inc = 1'b1;
                    end
                end
                ICACHE_MISS: begin
                    // A flush on the fill cycle still fills, but drops the reply.
                    if (mem.done) begin
                        we      = 1'b1;
                        req_d   = 1'b0;
                        state_d = ICACHE_IDLE;
                        if (!flush) begin
                            valid_d = 1'b1;
                            inst_d  = mem.data;
                        end
                    end else if (flush) begin
                        state_d = ICACHE_WAIT_DROP;
                    end
                end
                ICACHE_WAIT_DROP: begin
                    if (mem.done) begin
                        we      = 1'b1;
                        req_d   = 1'b0;
                        state_d = ICACHE_IDLE;
                    end
                end
                default: state_d = ICACHE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ICACHE_IDLE;
            valid_q <= 1'b0;
            inst_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign fetch.ready = (state_q == ICACHE_IDLE);
    assign fetch.valid = valid_q;
    assign fetch.inst  = inst_q;
    assign mem.req     = req_q;
    assign mem.addr    = addr_q;

    wire unused_pc_lo = ^fetch.pc[1:0];

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_inc)  hit_q  <= hit_q + 32'd1;
            if (miss_inc) miss_q <= miss_q + 32'd1;
        end
    end

    assign perf_hit  = hit_q;
    assign perf_miss = miss_q;
`else
    wire unused_perf = hit_inc ^ miss_inc;

    assign perf_hit  = 32'b0;
    assign perf_miss = 32'b0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios, then random fetches
// checked against an array-based cache model and a MemCtrl latency model.
module tb_icache;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    logic [31:0] perf_hit, perf_miss;

    icache_fetch_if f ();
    icache_mem_if   m ();

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .fetch     (f.slave),
        .mem       (m.master),
        .perf_hit  (perf_hit),
        .perf_miss (perf_miss)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hit   = 0;
    int n_miss  = 0;

    bit          mvalid [64];
    logic [23:0] mtag   [64];
    logic [31:0] mdata  [64];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A0_0093;
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic chk_perf();
`ifdef ICACHE_PERF_EN
        chk("perf_hit", perf_hit, n_hit);
        chk("perf_miss", perf_miss, n_miss);
`else
        chk("perf_hit", perf_hit, 32'd0);
        chk("perf_miss", perf_miss, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        n_hit  = 0;
        n_miss = 0;
    endtask

    // One fetch; fl_t/st_t are cycles after the miss starts (-1 = none).
    task automatic fetch(input logic [31:0] pc, input int lat,
                         input int fl_t, input int st_t, input int st_n);
        int          idx;
        logic [23:0] tg;
        logic [31:0] line;
        bit          hit, dropped, done;
        int          cnt;
        idx  = int'(pc[7:2]);
        tg   = pc[31:8];
        line = {pc[31:2], 2'b00};
        hit  = mvalid[idx] && (mtag[idx] == tg);
        chk("idle_ready", f.ready, 1);
        f.req = 1'b1;
        f.pc  = pc;
        step();
        f.req = 1'b0;
        if (hit) begin
            n_hit++;
            chk("hit_valid", f.valid, 1);
            chk("hit_inst", f.inst, mdata[idx]);
            chk("hit_noreq", m.req, 0);
            chk_perf();
            return;
        end
        n_miss++;
        chk("miss_req", m.req, 1);
        chk("miss_addr", m.addr, line);
        chk("miss_valid", f.valid, 0);
        chk("miss_ready", f.ready, 0);
        cnt     = 1;
        dropped = 1'b0;
        done    = 1'b0;
        for (int t = 1; t < 300 && !done; t++) begin
            rdy     = !(st_t >= 0 && t >= st_t && t < st_t + st_n);
            flush   = (t == fl_t);
            m.done  = rdy && (cnt == lat);
            m.data  = mem_word(line);
            if (flush && rdy) dropped = 1'b1;
            done = m.done;
            step();
            if (rdy) cnt++;
            rdy    = 1'b1;
            flush  = 1'b0;
            m.done = 1'b0;
            if (done) begin
                chk("fill_req", m.req, 0);
                chk("fill_ready", f.ready, 1);
                chk("fill_valid", f.valid, {31'b0, !dropped});
                if (!dropped) chk("fill_inst", f.inst, mem_word(line));
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
                mdata[idx]  = mem_word(line);
            end else begin
                chk("hold_req", m.req, 1);
                chk("hold_addr", m.addr, line);
                chk("hold_valid", f.valid, 0);
                chk("hold_ready", f.ready, 0);
            end
        end
        if (!done) chk("fill_timeout", 0, 1);
        chk_perf();
    endtask

    logic [23:0] tags [4];

    initial begin
        tags[0] = 24'h000000;
        tags[1] = 24'h000001;
        tags[2] = 24'hABCDE5;
        tags[3] = 24'hFFFFFF;
        f.req  = 1'b0;
        f.pc   = '0;
        m.done = 1'b0;
        m.data = '0;
        model_reset();
        #12;
        chk("rst_valid", f.valid, 0);
        chk("rst_inst", f.inst, 0);
        chk("rst_req", m.req, 0);
        chk("rst_addr", m.addr, 0);
        chk("rst_ready", f.ready, 1);
        chk_perf();
        step();
        rst = 1'b1;
        step();

        // Cold miss, then hit, then index conflict.
        fetch(32'h10, 5, -1, -1, 0);
        fetch(32'h10, 5, -1, -1, 0);
        fetch(32'h110, 6, -1, -1, 0);
        fetch(32'h10, 5, -1, -1, 0);
        fetch(32'h10, 5, -1, -1, 0);

        // Flush mid-miss, then the dropped line still hits.
        fetch(32'h20, 6, 2, -1, 0);
        fetch(32'h20, 5, -1, -1, 0);

        // rdy low for three cycles mid-miss.
        fetch(32'h30, 5, -1, 2, 3);
        fetch(32'h30, 5, -1, -1, 0);

        // Flush on the same cycle as mc_done.
        fetch(32'h40, 5, 5, -1, 0);
        fetch(32'h40, 5, -1, -1, 0);

        // Stray mc_done while idle.
        m.done = 1'b1;
        m.data = 32'hDEAD_BEEF;
        step();
        m.done = 1'b0;
        chk("stray_valid", f.valid, 0);
        chk("stray_req", m.req, 0);
        chk("stray_ready", f.ready, 1);
        fetch(32'h10, 5, -1, -1, 0);

        // Request together with flush is not accepted.
        f.req = 1'b1;
        f.pc  = 32'h10;
        flush = 1'b1;
        step();
        f.req = 1'b0;
        flush = 1'b0;
        chk("flushreq_valid", f.valid, 0);
        chk("flushreq_req", m.req, 0);
        chk_perf();

        // Reset in the middle of a miss.
        f.req = 1'b1;
        f.pc  = 32'h210;
        step();
        f.req = 1'b0;
        chk("rstmiss_req", m.req, 1);
        step();
        step();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rstmiss_req0", m.req, 0);
        chk("rstmiss_valid", f.valid, 0);
        chk("rstmiss_ready", f.ready, 1);
        chk("rstmiss_addr", m.addr, 0);
        chk_perf();
        step();
        rst = 1'b1;
        step();
        fetch(32'h10, 5, -1, -1, 0);
        fetch(32'h10, 5, -1, -1, 0);

        // Random traffic over a small, conflict-heavy address set.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] pc;
            int lat, fl_t, st_t, gap;
            pc   = {tags[$urandom_range(0, 3)], 3'b000,
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            lat  = $urandom_range(5, 9);
            fl_t = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat + 1) : -1;
            st_t = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : -1;
            fetch(pc, lat, fl_t, st_t, $urandom_range(1, 4));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                chk("gap_valid", f.valid, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
